// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - ID/EX issue register: ALU control decode, operand forwarding, stall/flush.
// Optional feature macro: ALU_ISSUE_FWD_EN enables EX/MEM and MEM/WB forwarding.
module alu_issue #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [1:0]         id_alu_op,
    input  logic [5:0]         id_funct,
    input  logic               id_alu_src,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic [XLEN-1:0]    id_rs_data,
    input  logic [XLEN-1:0]    id_rt_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [4:0]         id_shamt,
    input  logic               exm_wr,
    input  logic [RADDR_W-1:0] exm_rd,
    input  logic [XLEN-1:0]    exm_data,
    input  logic               wb_wr,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               ex_valid,
    output logic [2:0]         ex_ctl,
    output logic [XLEN-1:0]    ex_a,
    output logic [XLEN-1:0]    ex_b,
    output logic [4:0]         ex_shamt,
    output logic [XLEN-1:0]    ex_rt_fwd,
    output logic               ex_illegal
);

    localparam logic [2:0] CTL_ADD = 3'b010;
    localparam logic [2:0] CTL_SUB = 3'b110;
    localparam logic [2:0] CTL_AND = 3'b000;
    localparam logic [2:0] CTL_OR  = 3'b001;
    localparam logic [2:0] CTL_SLT = 3'b111;
    localparam logic [2:0] CTL_SLL = 3'b011;

    logic               valid_q;
    logic [2:0]         ctl_q;
    logic               illegal_q;
    logic [4:0]         shamt_q;
    logic [XLEN-1:0]    imm_q;
    logic [RADDR_W-1:0] rs_q;
    logic [RADDR_W-1:0] rt_q;
    logic               alu_src_q;
    logic               branch_q;
    logic [XLEN-1:0]    rs_data_q;
    logic [XLEN-1:0]    rt_data_q;

    logic [2:0]         dec_ctl;
    logic               dec_illegal;
    logic [XLEN-1:0]    fwd_rs;
    logic [XLEN-1:0]    fwd_rt;

    // Bubbles decode as a clean add so the ALU never sees a stale code.
    always_comb begin
        dec_ctl     = CTL_ADD;
        dec_illegal = 1'b0;
        if (id_valid) begin
            case (id_alu_op)
                2'b00: dec_ctl = CTL_ADD;
                2'b01: dec_ctl = CTL_SUB;
                2'b10: begin
                    case (id_funct)
                        6'h20:   dec_ctl = CTL_ADD;
                        6'h22:   dec_ctl = CTL_SUB;
                        6'h24:   dec_ctl = CTL_AND;
                        6'h25:   dec_ctl = CTL_OR;
                        6'h2A:   dec_ctl = CTL_SLT;
                        6'h00:   dec_ctl = CTL_SLL;
                        default: dec_illegal = 1'b1;
                    endcase
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

`ifdef ALU_ISSUE_FWD_EN
    // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
    always_comb begin
        fwd_rs = rs_data_q;
        if (exm_wr && (exm_rd != '0) && (exm_rd == rs_q)) begin
            fwd_rs = exm_data;
        end else if (wb_wr && (wb_rd != '0) && (wb_rd == rs_q)) begin
            fwd_rs = wb_data;
        end
    end

    always_comb begin
        fwd_rt = rt_data_q;
        if (exm_wr && (exm_rd != '0) && (exm_rd == rt_q)) begin
            fwd_rt = exm_data;
        end else if (wb_wr && (wb_rd != '0) && (wb_rd == rt_q)) begin
            fwd_rt = wb_data;
        end
    end
`else
    logic unused_fwd;

    assign fwd_rs     = rs_data_q;
    assign fwd_rt     = rt_data_q;
    assign unused_fwd = ^{exm_wr, exm_rd, exm_data, wb_wr, wb_rd, wb_data, rs_q, rt_q};
`endif

    // A stall recaptures the forwarded values so a producer retiring mid-stall is kept.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            valid_q   <= 1'b0;
            ctl_q     <= CTL_ADD;
            illegal_q <= 1'b0;
            shamt_q   <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            alu_src_q <= 1'b0;
            branch_q  <= 1'b0;
            rs_data_q <= '0;
            rt_data_q <= '0;
        end else if (stall) begin
            rs_data_q <= fwd_rs;
            rt_data_q <= fwd_rt;
        end else begin
            valid_q   <= id_valid;
            ctl_q     <= dec_ctl;
            illegal_q <= dec_illegal;
            shamt_q   <= id_shamt;
            imm_q     <= id_imm;
            rs_q      <= id_rs;
            rt_q      <= id_rt;
            alu_src_q <= id_alu_src;
            branch_q  <= (id_alu_op == 2'b01);
            rs_data_q <= id_rs_data;
            rt_data_q <= id_rt_data;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_ctl     = ctl_q;
    assign ex_illegal = illegal_q;
    assign ex_shamt   = shamt_q;
    assign ex_a       = fwd_rs;
    assign ex_rt_fwd  = fwd_rt;
    assign ex_b       = (alu_src_q && !branch_q) ? imm_q : fwd_rt;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue: directed spec cases plus randomized traffic.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid, id_alu_src;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic [4:0]  id_rs, id_rt, id_shamt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        exm_wr, wb_wr;
    logic [4:0]  exm_rd, wb_rd;
    logic [31:0] exm_data, wb_data;
    logic        ex_valid, ex_illegal;
    logic [2:0]  ex_ctl;
    logic [31:0] ex_a, ex_b, ex_rt_fwd;
    logic [4:0]  ex_shamt;

    int checks = 0;
    int errors = 0;

    alu_issue #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_alu_op(id_alu_op), .id_funct(id_funct), .id_alu_src(id_alu_src),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt),
        .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
        .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ctl(ex_ctl), .ex_a(ex_a), .ex_b(ex_b),
        .ex_shamt(ex_shamt), .ex_rt_fwd(ex_rt_fwd), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    // R-type funct -> ALU control table
    logic [5:0] ftab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    logic [2:0] ctab [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b011};

    typedef struct {
        logic        v;
        logic [2:0]  ctl;
        logic        ill;
        logic        dchk;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rtf;
        logic [4:0]  sh;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Abstract contents of the issued instruction slot
    logic        m_valid = 1'b0, m_ill = 1'b0, m_clean = 1'b0, m_src = 1'b0, m_br = 1'b0;
    logic [2:0]  m_ctl = 3'b010;
    logic [4:0]  m_rs = '0, m_rt = '0, m_sh = '0;
    logic [31:0] m_rsd = '0, m_rtd = '0, m_imm = '0;

    function automatic logic [31:0] mfwd(input logic [4:0] r, input logic [31:0] d);
`ifdef ALU_ISSUE_FWD_EN
        if (exm_wr && exm_rd != 5'd0 && exm_rd == r) return exm_data;
        if (wb_wr && wb_rd != 5'd0 && wb_rd == r) return wb_data;
`endif
        return d;
    endfunction

    function automatic void mdec(input logic v, input logic [1:0] op, input logic [5:0] f,
                                 output logic [2:0] ctl, output logic ill);
        ctl = 3'b010;
        ill = 1'b0;
        if (!v) return;
        if (op == 2'b00) return;
        if (op == 2'b01) begin ctl = 3'b110; return; end
        if (op == 2'b11) begin ill = 1'b1; return; end
        ill = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (ftab[i] == f) begin ctl = ctab[i]; ill = 1'b0; end
        end
    endfunction

    task automatic model_edge();
        logic [31:0] nrs, nrt;
        logic [2:0]  c;
        logic        il;
        if (!rst || flush) begin
            m_valid = 0; m_ctl = 3'b010; m_ill = 0; m_clean = 1; m_src = 0; m_br = 0;
            m_rs = 0; m_rt = 0; m_sh = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
        end else if (stall) begin
            nrs = mfwd(m_rs, m_rsd);
            nrt = mfwd(m_rt, m_rtd);
            m_rsd = nrs;
            m_rtd = nrt;
        end else begin
            mdec(id_valid, id_alu_op, id_funct, c, il);
            m_valid = id_valid; m_ctl = c; m_ill = il; m_clean = 0;
            m_src = id_alu_src; m_br = (id_alu_op == 2'b01);
            m_rs = id_rs; m_rt = id_rt; m_sh = id_shamt;
            m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm;
        end
    endtask

    // Push the expectation for the current window, then advance one edge.
    task automatic cycle();
        exp_t e;
        e.v    = m_valid;
        e.ctl  = m_ctl;
        e.ill  = m_ill;
        e.dchk = m_valid || m_clean;
        e.a    = mfwd(m_rs, m_rsd);
        e.rtf  = mfwd(m_rt, m_rtd);
        e.b    = (m_src && !m_br) ? m_imm : e.rtf;
        e.sh   = m_sh;
        exp_q.push_back(e);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, mon_e.v});
            chk("ex_ctl", {29'd0, ex_ctl}, {29'd0, mon_e.ctl});
            chk("ex_illegal", {31'd0, ex_illegal}, {31'd0, mon_e.ill});
            if (mon_e.dchk) begin
                chk("ex_a", ex_a, mon_e.a);
                chk("ex_b", ex_b, mon_e.b);
                chk("ex_rt_fwd", ex_rt_fwd, mon_e.rtf);
                chk("ex_shamt", {27'd0, ex_shamt}, {27'd0, mon_e.sh});
            end
        end
    end

    task automatic ctl_idle();
        rst = 1; stall = 0; flush = 0;
        exm_wr = 0; exm_rd = 0; exm_data = 0;
        wb_wr = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic set_id(input logic v, input logic [1:0] op, input logic [5:0] f, input logic src,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic [31:0] imm);
        id_valid = v; id_alu_op = op; id_funct = f; id_alu_src = src;
        id_rs = rs; id_rt = rt; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_shamt = $urandom_range(0, 31);
    endtask

    task automatic rand_inputs();
        int k;
        rst   = ($urandom_range(0, 49) != 0);
        stall = ($urandom_range(0, 3) == 0);
        flush = ($urandom_range(0, 9) == 0);
        k = $urandom_range(0, 7);
        id_alu_op  = (k < 2) ? 2'b00 : (k == 2) ? 2'b01 : (k == 7) ? 2'b11 : 2'b10;
        k = $urandom_range(0, 9);
        id_funct   = (k < 6) ? ftab[k] : 6'($urandom);
        id_valid   = ($urandom_range(0, 4) != 0);
        id_alu_src = 1'($urandom);
        id_rs      = 5'($urandom_range(0, 7));
        id_rt      = 5'($urandom_range(0, 7));
        id_rs_data = $urandom;
        id_rt_data = $urandom;
        id_imm     = $urandom;
        id_shamt   = 5'($urandom);
        exm_wr     = 1'($urandom);
        exm_rd     = 5'($urandom_range(0, 7));
        exm_data   = $urandom;
        wb_wr      = 1'($urandom);
        wb_rd      = 5'($urandom_range(0, 7));
        wb_data    = $urandom;
    endtask

    initial begin
        ctl_idle();
        set_id(1, 2'b10, 6'h22, 0, 5'd1, 5'd2, 32'h11, 32'h22, 32'h33);
        rst = 0;
        @(posedge clk);
        model_edge();
        #1;
        cycle();
        rst = 1;

        // decode sweep including the unsupported nor funct
        for (int i = 0; i < 6; i++) begin
            set_id(1, 2'b10, ftab[i], 0, 5'd1, 5'd2, $urandom, $urandom, $urandom);
            cycle();
        end
        set_id(1, 2'b10, 6'h27, 0, 5'd1, 5'd2, 32'h5, 32'h6, 32'h7);
        cycle();
        set_id(1, 2'b11, 6'h20, 0, 5'd1, 5'd2, 32'h5, 32'h6, 32'h7);
        cycle();

        // forwarding priority
        set_id(1, 2'b10, 6'h20, 0, 5'd3, 5'd4, 32'h1, 32'h2, 32'h0);
        exm_wr = 1; exm_rd = 5'd3; exm_data = 32'hAA;
        wb_wr = 1; wb_rd = 5'd3; wb_data = 32'hBB;
        cycle();
        cycle();
        exm_wr = 0;
        cycle();
        set_id(1, 2'b10, 6'h20, 0, 5'd0, 5'd0, 32'h1, 32'h2, 32'h0);
        exm_wr = 1; exm_rd = 5'd0; wb_rd = 5'd0;
        cycle();
        cycle();
        ctl_idle();

        // addi immediate, then beq ignoring alu_src
        set_id(1, 2'b00, 6'h00, 1, 5'd1, 5'd2, 32'h10, 32'h20, 32'hFFFFFFFC);
        cycle();
        set_id(1, 2'b01, 6'h00, 1, 5'd1, 5'd2, 32'h10, 32'h20, 32'h12345678);
        wb_wr = 1; wb_rd = 5'd2; wb_data = 32'hCAFE;
        cycle();
        cycle();
        ctl_idle();

        // stall while a producer retires
        set_id(1, 2'b10, 6'h25, 0, 5'd5, 5'd6, 32'h0, 32'h9, 32'h0);
        cycle();
        stall = 1;
        set_id(1, 2'b10, 6'h22, 0, 5'd7, 5'd7, 32'h77, 32'h77, 32'h0);
        exm_wr = 1; exm_rd = 5'd5; exm_data = 32'h1234;
        cycle();
        exm_wr = 0;
        cycle();
        cycle();
        stall = 0;
        cycle();

        // flush wins over stall
        stall = 1; flush = 1;
        cycle();
        stall = 0; flush = 0;
        set_id(1, 2'b00, 6'h00, 0, 5'd1, 5'd2, 32'h3, 32'h4, 32'h0);
        cycle();
        cycle();

        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            cycle();
        end
        ctl_idle();
        cycle();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drained actual=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
